// File: rtl/mux_pipe_skid.sv
// N-way, W-bit selector with a registered output stage and a 2-entry skid buffer.
// The select is combinational on the input side. Only the selected word, its
// select and its error flag are registered. in_ready is registered, so it never
// depends combinationally on out_ready.
module mux_pipe_skid #(
    parameter int              WIDTH   = 5,
    parameter int              NUM_IN  = 4,
    parameter int              SEL_W   = 2,
    parameter logic [WIDTH-1:0] DEF_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // One buffered entry: the selected word plus the select that produced it
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } ent_t;

    // State is {skid_valid, out_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0] state_q, state_d;
    ent_t       main_q, main_d;
    ent_t       skid_q, skid_d;
    ent_t       in_ent;
    logic       accept, xfer;

    // Input-side select; out-of-range selects substitute DEF_VAL and flag err
    always_comb begin
        in_ent.data = DEF_VAL;
        in_ent.sel  = sel;
        in_ent.err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                in_ent.data = in_bus[k*WIDTH +: WIDTH];
                in_ent.err  = 1'b0;
            end
        end
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_err   = main_q.err;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    // Next-state: main register feeds the outputs, skid catches one word of back-pressure
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Only valid bits clear; payload registers keep their last values
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        main_d = in_ent;
                    end else if (accept) begin
                        skid_d  = in_ent;
                        state_d = ST_FULL;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and payload registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_mux_pipe_skid.sv
// Bench for mux_pipe_skid: a queue-based model of a 2-deep FIFO whose head drives
// the outputs, checked every cycle, plus hand-computed literal expectations.
module tb_mux_pipe_skid;

    localparam int         WIDTH  = 5;
    localparam int         NUM_IN = 3;
    localparam int         SEL_W  = 2;
    localparam logic [4:0] DEFV   = 5'h1F;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid, in_ready, flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err, out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    mux_pipe_skid #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEF_VAL(DEFV)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most two entries; the head is what the
    // outputs show, and the payload outputs keep the last head when empty.
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
        logic             e;
    } ent_t;

    ent_t q[$];
    ent_t disp;
    bit   started = 0;

    always @(posedge clk) begin
        ent_t w;
        bit   acc, xfr;
        if (!rst_n) begin
            q.delete();
            disp    = '{d: '0, s: '0, e: 1'b0};
            started = 1;
        end else if (started) begin
            acc = in_valid && (q.size() < 2);
            xfr = (q.size() > 0) && out_ready;
            w.s = sel;
            if (int'(sel) < NUM_IN) begin
                w.d = in_bus[int'(sel)*WIDTH +: WIDTH];
                w.e = 1'b0;
            end else begin
                w.d = DEFV;
                w.e = 1'b1;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (xfr) void'(q.pop_front());
                if (acc) q.push_back(w);
                if (q.size() > 0) disp = q[0];
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready",  32'(in_ready),  32'(q.size() < 2));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_out_data",  32'(out_data),  32'(disp.d));
            chk("m_out_sel",   32'(out_sel),   32'(disp.s));
            chk("m_out_err",   32'(out_err),   32'(disp.e));
        end
    end

    // Place value v on channel s, random values on the other channels
    task automatic put(input logic [WIDTH-1:0] v, input int s);
        in_bus = 15'($urandom);
        sel    = SEL_W'(s);
        if (s < NUM_IN) in_bus[s*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        rst_n = 0; in_bus = '0; sel = '0; in_valid = 0; flush = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready),  1);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_sel",   32'(out_sel),   0);
        chk("rst_err",   32'(out_err),   0);
        rst_n = 1;

        // Basic select with one-cycle latency
        in_bus = {5'd2, 5'd1, 5'd0}; sel = 2'd2; in_valid = 1; out_ready = 1;
        @(negedge clk);
        chk("t1_data", 32'(out_data), 2);
        chk("t1_sel",  32'(out_sel),  2);
        chk("t1_err",  32'(out_err),  0);
        chk("t1_vld",  32'(out_valid), 1);

        // Out-of-range select substitutes the default value
        sel = 2'd3;
        @(negedge clk);
        chk("t2_data", 32'(out_data), 32'h1F);
        chk("t2_err",  32'(out_err),  1);
        chk("t2_sel",  32'(out_sel),  3);

        // Back-pressure fills the skid, then drains in order
        in_valid = 0;
        @(negedge clk);
        out_ready = 0; in_valid = 1; put(5'd7, 0);
        @(negedge clk);
        chk("t3_a_data", 32'(out_data), 7);
        put(5'd9, 1);
        @(negedge clk);
        chk("t3_full_rdy", 32'(in_ready), 0);
        chk("t3_hold",     32'(out_data), 7);
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("t3_b_data", 32'(out_data), 9);
        chk("t3_rdy",    32'(in_ready), 1);
        @(negedge clk);
        chk("t3_empty",  32'(out_valid), 0);

        // Streaming at full rate
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; put(5'(i), i % NUM_IN);
            @(negedge clk);
            chk("t4_data", 32'(out_data), 32'(i));
            chk("t4_rdy",  32'(in_ready), 1);
        end
        in_valid = 0;
        @(negedge clk);

        // Flush while FULL with a word offered
        out_ready = 0; in_valid = 1; put(5'd4, 0);
        @(negedge clk);
        put(5'd6, 1);
        @(negedge clk);
        chk("t5_full", 32'(in_ready), 0);
        flush = 1; put(5'd12, 2);
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("t5_vld",  32'(out_valid), 0);
        chk("t5_rdy",  32'(in_ready),  1);
        chk("t5_keep", 32'(out_data),  4);
        out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_idle", 32'(out_valid), 0);
        end
        // Flush in ONE with a same-cycle accept: the accepted word is dropped
        out_ready = 0; in_valid = 1; put(5'd10, 0);
        @(negedge clk);
        put(5'd13, 1); flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("t5b_vld",  32'(out_valid), 0);
        chk("t5b_keep", 32'(out_data),  10);

        // Reset while FULL, then first word with one-cycle latency
        in_valid = 1; put(5'd1, 0);
        @(negedge clk);
        put(5'd2, 1);
        @(negedge clk);
        chk("t6_full", 32'(in_ready), 0);
        rst_n = 0; in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        chk("t6_vld",  32'(out_valid), 0);
        chk("t6_data", 32'(out_data),  0);
        chk("t6_sel",  32'(out_sel),   0);
        chk("t6_rdy",  32'(in_ready),  1);
        in_valid = 1; out_ready = 1; put(5'd5, 2);
        @(negedge clk);
        chk("t6_first", 32'(out_data), 5);
        chk("t6_fvld",  32'(out_valid), 1);
        chk("t6_fsel",  32'(out_sel),  2);
        in_valid = 0;
        @(negedge clk);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            put(5'($urandom), $urandom_range(0, 3));
            flush     = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
